pwm_duty_ctrl: RTL and testbench

PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

---
 rtl/pwm_duty_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: multi-channel PWM generator with button-driven duty control.
// Three raw buttons (up, dn, sel) are synchronized and debounced, turned into
// one-cycle press pulses, and used to step the duty of the selected channel.
// Each channel's duty is latched into a shadow register at the start of every
// PWM period so that mid-period edits never distort the running waveform.
// Optional feature macro: PWM_AUTOREPEAT_EN
//   When defined, holding up or dn emits an extra press every REPEAT cycles
//   after the initial press. When undefined, no repeat counters exist.

module pwm_duty_ctrl #(
   parameter int CH     = 2,
   parameter int RES    = 8,
   parameter int DIV    = 5000,
   parameter int DEB    = 250000,
   parameter int STEP   = 16,
   parameter int REPEAT = 5000000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           btn_up,
   input  logic           btn_dn,
   input  logic           btn_sel,
   output logic [CH-1:0]  pwm,
   output logic [3:0]     sel_ch,
   output logic [RES-1:0] duty_disp
);

   // Button index map used by every per-button array below.
   localparam int NB     = 3;
   localparam int B_UP   = 0;
   localparam int B_DN   = 1;
   localparam int B_SEL  = 2;

   localparam int DW     = (DEB > 1) ? $clog2(DEB + 1) : 1;
   localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW     = (CH > 1) ? $clog2(CH) : 1;

   // Duty arithmetic is done one bit wider so an up-step can never wrap.
   localparam logic [RES:0]   DMAX   = {1'b0, {RES{1'b1}}};
   localparam logic [RES:0]   STEPW  = (RES + 1)'(STEP);
   localparam logic [DW-1:0]  DEBEND = DW'(DEB - 1);
   localparam logic [PW-1:0]  PSCEND = PW'(DIV - 1);
   localparam logic [SW-1:0]  SELEND = SW'(CH - 1);

   logic [NB-1:0]  rawBtn;
   logic [NB-1:0]  syncA;
   logic [NB-1:0]  syncB;
   logic [NB-1:0]  btnLevel;
   logic [NB-1:0]  btnLevelQ;
   logic [NB-1:0]  press;
   logic [DW-1:0]  debCnt [NB];

   logic           upPress;
   logic           dnPress;
   logic           selPress;

   logic [SW-1:0]  selIdx;
   logic [RES-1:0] duty   [CH];
   logic [RES-1:0] shadow [CH];
   logic [RES:0]   upSum;
   logic [RES-1:0] upVal;
   logic [RES-1:0] dnVal;

   logic [PW-1:0]  presc;
   logic           tick;
   logic [RES-1:0] periodCnt;
   logic           periodWrap;

   assign rawBtn = {btn_sel, btn_dn, btn_up};

   // Two-flop synchronizer bringing the asynchronous buttons into the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         syncA <= '0;
         syncB <= '0;
      end else begin
         syncA <= rawBtn;
         syncB <= syncA;
      end
   end

   // Debounce: the level follows the synchronized input only after it has
   // disagreed for DEB consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         btnLevel <= '0;
         for (int b = 0; b < NB; b++) begin
            debCnt[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (syncB[b] != btnLevel[b]) begin
               if (debCnt[b] == DEBEND) begin
                  btnLevel[b] <= syncB[b];
                  debCnt[b]   <= '0;
               end else begin
                  debCnt[b] <= debCnt[b] + DW'(1);
               end
            end else begin
               debCnt[b] <= '0;
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         btnLevelQ <= '0;
      end else begin
         btnLevelQ <= btnLevel;
      end
   end

   assign press = btnLevel & ~btnLevelQ;

`ifdef PWM_AUTOREPEAT_EN
   localparam int            RW     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [RW-1:0] RPTEND = RW'(REPEAT - 1);

   logic [RW-1:0] rptCnt [2];
   logic [1:0]    rptPulse;

   // Repeat timers for up and dn: restart on the initial press and whenever
   // the button is released, then fire every REPEAT cycles while it is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptCnt[0] <= '0;
         rptCnt[1] <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (!btnLevel[b] || press[b]) begin
               rptCnt[b] <= '0;
            end else if (rptCnt[b] == RPTEND) begin
               rptCnt[b] <= '0;
            end else begin
               rptCnt[b] <= rptCnt[b] + RW'(1);
            end
         end
      end
   end

   // A repeat pulse only counts once the button has been held past its press.
   always_comb begin
      rptPulse = '0;
      for (int b = 0; b < 2; b++) begin
         rptPulse[b] = btnLevel[b] & btnLevelQ[b] & (rptCnt[b] == RPTEND);
      end
   end

   assign upPress = press[B_UP] | rptPulse[B_UP];
   assign dnPress = press[B_DN] | rptPulse[B_DN];
`else
   assign upPress = press[B_UP];
   assign dnPress = press[B_DN];
`endif

   assign selPress = press[B_SEL];

   // Saturating candidate values for the currently selected channel.
   always_comb begin
      upSum = {1'b0, duty[selIdx]} + STEPW;
      upVal = (upSum > DMAX) ? DMAX[RES-1:0] : upSum[RES-1:0];
      if ({1'b0, duty[selIdx]} < STEPW) begin
         dnVal = '0;
      end else begin
         dnVal = duty[selIdx] - STEPW[RES-1:0];
      end
   end

   // Duty registers: up and dn together cancel; a simultaneous sel press still
   // applies the change to the channel that was selected before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            duty[i] <= '0;
         end
      end else if (upPress ^ dnPress) begin
         duty[selIdx] <= upPress ? upVal : dnVal;
      end
   end

   // Channel selector, wrapping from the last channel back to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         selIdx <= '0;
      end else if (selPress) begin
         selIdx <= (selIdx == SELEND) ? '0 : selIdx + SW'(1);
      end
   end

   assign sel_ch    = 4'(selIdx);
   assign duty_disp = duty[selIdx];

   assign tick       = (presc == PSCEND);
   assign periodWrap = tick && (periodCnt == {RES{1'b1}});

   // Prescaler producing one tick every DIV clk cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Free-running period counter advanced once per tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         periodCnt <= '0;
      end else if (tick) begin
         periodCnt <= periodCnt + RES'(1);
      end
   end

   // Shadow duties are refreshed only as the period counter wraps to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            shadow[i] <= '0;
         end
      end else if (periodWrap) begin
         for (int i = 0; i < CH; i++) begin
            shadow[i] <= duty[i];
         end
      end
   end

   // Registered compare gives glitch-free outputs one clk behind the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm <= '0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            pwm[i] <= (periodCnt < shadow[i]);
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Testbench for pwm_duty_ctrl with small parameters. A behavioural model
// predicts pwm, sel_ch and duty_disp every cycle from the raw button history
// and the elapsed cycle count since reset; directed scenarios add fixed
// expectations for glitch rejection, saturation, selection and PWM shape.
// Define PWM_AUTOREPEAT_EN for both files to exercise auto-repeat.

module tb_pwm_duty_ctrl;

   localparam int CH     = 2;
   localparam int RES    = 4;
   localparam int DIV    = 2;
   localparam int DEB    = 4;
   localparam int STEP   = 4;
   localparam int REPEAT = 20;
   localparam int PERIOD = 1 << RES;
   localparam int MAXD   = PERIOD - 1;

   localparam logic [2:0] M_UP  = 3'b001;
   localparam logic [2:0] M_DN  = 3'b010;
   localparam logic [2:0] M_SEL = 3'b100;

   logic           clk;
   logic           rst;
   logic           btn_up;
   logic           btn_dn;
   logic           btn_sel;
   logic [CH-1:0]  pwm;
   logic [3:0]     sel_ch;
   logic [RES-1:0] duty_disp;

   int testsRun;
   int testsFailed;

   // Reference model state
   int         mDuty   [CH];
   int         mShadow [CH];
   int         mPwm    [CH];
   int         mSel;
   int         mCycle;
   bit         mLvl    [3];
   bit         mLvlQ   [3];
   int         mHold   [2];
   logic [2:0] hist [$];

   pwm_duty_ctrl #(
      .CH(CH), .RES(RES), .DIV(DIV), .DEB(DEB), .STEP(STEP), .REPEAT(REPEAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_up(btn_up),
      .btn_dn(btn_dn),
      .btn_sel(btn_sel),
      .pwm(pwm),
      .sel_ch(sel_ch),
      .duty_disp(duty_disp)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 2 ms");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Raw input seen n-k edges ago; anything before reset reads as zero.
   function automatic bit rawAt(input int b, input int k);
      int idx;
      idx = hist.size() - 1 - k;
      if (idx < 0) return 1'b0;
      return hist[idx][b];
   endfunction

   // Model of one rising clock edge given the inputs applied before it.
   task automatic modelEdge(input bit up, input bit dn, input bit sel, input bit rstv);
      int  cntB;
      bit  pr [3];
      bit  allDiff;
      if (rstv) begin
         for (int i = 0; i < CH; i++) begin
            mDuty[i] = 0; mShadow[i] = 0; mPwm[i] = 0;
         end
         mSel = 0; mCycle = 0;
         for (int b = 0; b < 3; b++) begin
            mLvl[b] = 0; mLvlQ[b] = 0;
         end
         mHold[0] = 0; mHold[1] = 0;
         hist.delete();
         return;
      end
      mCycle++;
      // Position inside the period is pure arithmetic on elapsed cycles.
      cntB = ((mCycle - 1) / DIV) % PERIOD;
      for (int i = 0; i < CH; i++) mPwm[i] = (cntB < mShadow[i]) ? 1 : 0;
      if (mCycle % (DIV * PERIOD) == 0) begin
         for (int i = 0; i < CH; i++) mShadow[i] = mDuty[i];
      end
      for (int b = 0; b < 3; b++) pr[b] = mLvl[b] && !mLvlQ[b];
`ifdef PWM_AUTOREPEAT_EN
      for (int b = 0; b < 2; b++) begin
         if (pr[b]) begin
            mHold[b] = 0;
         end else if (mLvl[b] && mLvlQ[b]) begin
            mHold[b]++;
            if (mHold[b] % REPEAT == 0) pr[b] = 1;
         end
      end
`endif
      if (pr[0] && !pr[1]) mDuty[mSel] = (mDuty[mSel] + STEP > MAXD) ? MAXD : mDuty[mSel] + STEP;
      if (pr[1] && !pr[0]) mDuty[mSel] = (mDuty[mSel] < STEP) ? 0 : mDuty[mSel] - STEP;
      if (pr[2]) mSel = (mSel + 1) % CH;
      for (int b = 0; b < 3; b++) mLvlQ[b] = mLvl[b];
      hist.push_back({sel, dn, up});
      if (hist.size() > 32) void'(hist.pop_front());
      // Level flips once the synchronized value (two edges late) has
      // disagreed with it over the last DEB edges.
      for (int b = 0; b < 3; b++) begin
         allDiff = 1;
         for (int k = 2; k <= DEB + 1; k++) begin
            if (rawAt(b, k) == mLvl[b]) allDiff = 0;
         end
         if (allDiff) mLvl[b] = !mLvl[b];
      end
   endtask

   // One clock cycle: drive, step DUT and model, compare away from the edge.
   task automatic applyStimulus(input bit up, input bit dn, input bit sel, input bit rstv);
      logic [CH-1:0] expPwm;
      btn_up = up; btn_dn = dn; btn_sel = sel; rst = rstv;
      @(posedge clk);
      modelEdge(up, dn, sel, rstv);
      @(negedge clk);
      for (int i = 0; i < CH; i++) expPwm[i] = mPwm[i][0];
      checkOutput("pwm", 32'(pwm), 32'(expPwm));
      checkOutput("sel_ch", 32'(sel_ch), 32'(mSel));
      checkOutput("duty_disp", 32'(duty_disp), 32'(mDuty[mSel]));
   endtask

   task automatic pressBtn(input logic [2:0] mask, input int hold, input int gap);
      for (int i = 0; i < hold; i++) applyStimulus(mask[0], mask[1], mask[2], 1'b0);
      for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Count pwm high cycles per channel over one full period of clk cycles;
   // optionally hold btn_up for the first upHold cycles.
   task automatic countPeriod(input int upHold, output int hi0, output int hi1);
      hi0 = 0; hi1 = 0;
      for (int i = 0; i < DIV * PERIOD; i++) begin
         applyStimulus(i < upHold, 1'b0, 1'b0, 1'b0);
         if (pwm[0] === 1'b1) hi0++;
         if (pwm[1] === 1'b1) hi1++;
      end
   endtask

   initial begin
      int expUp [5];
      int expDn [5];
      int hi0;
      int hi1;
      int guard;
      int expRpt;
      logic [2:0] mask;
      int hold;
      int gap;

      testsRun = 0;
      testsFailed = 0;
      btn_up = 0; btn_dn = 0; btn_sel = 0; rst = 1;
      expUp = '{4, 8, 12, 15, 15};
      expDn = '{11, 7, 3, 0, 0};

      // Reset state
      doReset(3);
      checkOutput("rst_pwm", 32'(pwm), 0);
      checkOutput("rst_sel", 32'(sel_ch), 0);
      checkOutput("rst_disp", 32'(duty_disp), 0);

      // Short glitch is rejected, a long hold gives exactly one press
      pressBtn(M_UP, 3, 10);
      checkOutput("glitch_disp", 32'(duty_disp), 0);
      pressBtn(M_UP, 10, 10);
      checkOutput("one_press_disp", 32'(duty_disp), 4);

      // Saturation upward and downward on channel 0
      doReset(2);
      for (int i = 0; i < 5; i++) begin
         pressBtn(M_UP, 8, 8);
         checkOutput("sat_up", 32'(duty_disp), 32'(expUp[i]));
      end
      for (int i = 0; i < 5; i++) begin
         pressBtn(M_DN, 8, 8);
         checkOutput("sat_dn", 32'(duty_disp), 32'(expDn[i]));
      end

      // Selection and cancelling up+dn
      pressBtn(M_UP, 8, 8);
      pressBtn(M_UP, 8, 8);
      pressBtn(M_SEL, 8, 8);
      checkOutput("sel1_ch", 32'(sel_ch), 1);
      checkOutput("sel1_disp", 32'(duty_disp), 0);
      pressBtn(M_SEL, 8, 8);
      checkOutput("sel0_ch", 32'(sel_ch), 0);
      checkOutput("sel0_disp", 32'(duty_disp), 8);
      pressBtn(M_UP | M_DN, 8, 8);
      checkOutput("updn_disp", 32'(duty_disp), 8);

      // PWM shape with duty0=8, then a mid-period change to 12
      guard = 0;
      while ((mCycle % (DIV * PERIOD)) != 0 && guard < 2 * DIV * PERIOD) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         guard++;
      end
      checkOutput("align_guard", 32'(guard < 2 * DIV * PERIOD), 1);
      countPeriod(0, hi0, hi1);
      checkOutput("per1_hi0", 32'(hi0), 16);
      checkOutput("per1_hi1", 32'(hi1), 0);
      countPeriod(0, hi0, hi1);
      checkOutput("per2_hi0", 32'(hi0), 16);
      countPeriod(10, hi0, hi1);
      checkOutput("midchg_hi0", 32'(hi0), 16);
      checkOutput("midchg_disp", 32'(duty_disp), 12);
      countPeriod(0, hi0, hi1);
      checkOutput("next_hi0", 32'(hi0), 24);
      checkOutput("next_hi1", 32'(hi1), 0);

      // Reset in the middle of a period with duty0=12 and channel 1 selected
      pressBtn(M_SEL, 8, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("midrst_pwm", 32'(pwm), 0);
      checkOutput("midrst_sel", 32'(sel_ch), 0);
      checkOutput("midrst_disp", 32'(duty_disp), 0);

      // Long hold: repeats only when the feature is built in
      doReset(2);
`ifdef PWM_AUTOREPEAT_EN
      expRpt = 12;
`else
      expRpt = 4;
`endif
      pressBtn(M_UP, 6 + 50, 12);
      checkOutput("long_hold_disp", 32'(duty_disp), 32'(expRpt));

      // Randomized presses with bounce, combinations and occasional resets
      for (int it = 0; it < 160; it++) begin
         case ($urandom_range(0, 9))
            0:       mask = M_UP | M_DN;
            1:       mask = M_SEL | M_UP;
            2:       mask = M_SEL | M_DN;
            3, 4:    mask = M_SEL;
            5, 6:    mask = M_DN;
            default: mask = M_UP;
         endcase
         hold = $urandom_range(1, 10);
         gap  = $urandom_range(1, 10);
         if ($urandom_range(0, 49) == 0) begin
            doReset(1);
         end else if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < hold; i++) begin
               applyStimulus(mask[0] & 1'($urandom), mask[1] & 1'($urandom),
                             mask[2] & 1'($urandom), 1'b0);
            end
            pressBtn(3'b000, 0, gap);
         end else begin
            pressBtn(mask, hold, gap);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
